// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte/half/word load-store requests into word-wide
// memory accesses, with read-modify-write for sub-word stores and error checking.
module load_store_unit #(
    parameter int DEPTH_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_di,
    input  logic [31:0] mem_rd,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits on ready, and payload is held while valid is unanswered.
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

    state_t      state;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [31:0] merge_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merged;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr[31:2] >= DEPTH_L)
            req_err = 1'b1;
    end

    // Little-endian lane extraction and sub-word merge, both relative to the latched address.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rd[7:0];
            2'd1:    ld_byte = mem_rd[15:8];
            2'd2:    ld_byte = mem_rd[23:16];
            default: ld_byte = mem_rd[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

        case (size_q)
            2'b00:   ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = mem_rd;
        endcase

        merged = mem_rd;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata[15:0];
                        merge_q   <= req_wdata;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        rsp_rdata <= '0;
                        rsp_err   <= req_err;
                        if (req_err)
                            state <= RESP;
                        else if (!req_we)
                            state <= LOAD;
                        else if (req_size == 2'b10)
                            state <= WRITE;
                        else
                            state <= MERGE;
                    end
                end
                LOAD: begin
                    rsp_rdata <= ld_data;
                    state     <= RESP;
                end
                MERGE: begin
                    merge_q <= merged;
                    state   <= WRITE;
                end
                WRITE: state <= RESP;
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from the state register only, so reset kills a pending write asynchronously.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_we    = (state == WRITE);
    assign mem_a     = (state == LOAD || state == MERGE || state == WRITE) ?
                       {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_di    = (state == WRITE) ? merge_q : 32'h0;
    assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, backpressure and reset
// sequences, then random traffic scored against a word-array reference model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_di;
    logic [31:0] mem_rd;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.DEPTH_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_rd(mem_rd),
        .dbg_state(dbg_state)
    );

    // Attached data memory: combinational read, write on rising edge.
    logic [31:0] mem [0:3] = '{default: 32'h0};
    assign mem_rd = mem[mem_a[3:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[3:2]] <= mem_di;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    vec_t vecs [18];
    logic [31:0] ref_mem [0:3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One full transaction with rsp_ready held high; lat counts edges after the accept edge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int wes);
        logic got;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wes = 0; got = 1'b0; rdata = '0; err = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_we) wes++;
            if (rsp_valid) begin
                got = 1'b1; rdata = rsp_rdata; err = rsp_err;
            end else begin
                lat++;
            end
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int wes);
        int idx, sh, nbits;
        logic [31:0] mask, v;
        idx = int'(addr >> 2);
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || ((addr >> 2) >= 4);
        rdata = 32'h0; lat = 0; wes = 0;
        if (err) return;
        nbits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        sh    = (size == 2'd0) ? 8 * int'(addr % 4) : (size == 2'd1) ? 16 * int'((addr >> 1) % 2) : 0;
        mask  = (nbits == 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        if (we) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
            lat = (size == 2'd2) ? 1 : 2;
            wes = 1;
        end else begin
            v = (ref_mem[idx] >> sh) & mask;
            if (!uns && nbits < 32 && v[nbits-1]) v = v | ~mask;
            rdata = v;
            lat = 1;
        end
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, wes, elat, ewes;
        logic        r_we, r_uns;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h4,  32'hDEADBEEF, 32'h0,        1'b0, 1, 1};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h4,  32'h0,        32'hDEADBEEF, 1'b0, 1, 0};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h4,  32'h11223344, 32'h0,        1'b0, 1, 1};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h6,  32'h123456A5, 32'h0,        1'b0, 2, 1};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h4,  32'h0,        32'h11A53344, 1'b0, 1, 0};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h6,  32'h0,        32'hFFFFFFA5, 1'b0, 1, 0};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h6,  32'h0,        32'h000000A5, 1'b0, 1, 0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0,  32'h80017FFF, 32'h0,        1'b0, 1, 1};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h2,  32'h0,        32'hFFFF8001, 1'b0, 1, 0};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h2,  32'h0,        32'h00008001, 1'b0, 1, 0};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0,  32'h0,        32'h00007FFF, 1'b0, 1, 0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h2,  32'hCAFECAFE, 32'h0,        1'b1, 0, 0};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 32'h5,  32'h0,        32'h0,        1'b1, 0, 0};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 32'h0,  32'hFFFFFFFF, 32'h0,        1'b1, 0, 0};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 0, 0};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h0,  32'h0,        32'h80017FFF, 1'b0, 1, 0};
        vecs[16] = '{1'b1, 2'b01, 1'b0, 32'h6,  32'h0000BEEF, 32'h0,        1'b0, 2, 1};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h4,  32'h0,        32'hBEEF3344, 1'b0, 1, 0};

        // Reset block
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
        check("rst_mem_we",    {31'b0, mem_we}, 32'd0);
        check("rst_mem_a",     mem_a, 32'd0);
        check("rst_mem_di",    mem_di, 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 18; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, wes);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we_cycles", i), 32'(wes), 32'(vecs[i].exp_wes));
        end
        check("mem_word0", mem[0], 32'h80017FFF);
        check("mem_word1", mem[1], 32'hBEEF3344);

        // Backpressure: response frozen while rsp_ready low, second request waits
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, rd, er, lat, wes);
        check("bp_store_err", {31'b0, er}, 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h8;
        @(posedge clk);
        #1 req_addr = 32'h0;
        @(negedge clk);
        check("bp_busy_ready", {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", i), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("bp_hold%0d_rdata", i), rsp_rdata, 32'h12345678);
            check($sformatf("bp_hold%0d_ready", i), {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_after_hs_ready", {31'b0, req_ready}, 32'd1);
        check("bp_after_hs_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp_second_busy", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("bp_second_valid", {31'b0, rsp_valid}, 32'd1);
        check("bp_second_rdata", rsp_rdata, 32'h80017FFF);
        @(posedge clk);

        // Reset during the write cycle of a byte store
        do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h55667788, rd, er, lat, wes);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'hD; req_wdata = 32'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_mem_we_before", {31'b0, mem_we}, 32'd1);
        check("rstw_mem_di", mem_di, 32'h5566EE88);
        #2 rst = 1'b1;
        #1;
        check("rstw_mem_we_async", {31'b0, mem_we}, 32'd0);
        check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
        check("rstw_mem_a", mem_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstw_mem_word3", mem[3], 32'h55667788);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstw_idle%0d_valid", i), {31'b0, rsp_valid}, 32'd0);
            check($sformatf("rstw_idle%0d_ready", i), {31'b0, req_ready}, 32'd1);
        end

        // Random traffic against the reference model
        ref_mem[0] = 32'h80017FFF; ref_mem[1] = 32'hBEEF3344;
        ref_mem[2] = 32'h12345678; ref_mem[3] = 32'h55667788;
        for (int i = 0; i < 150; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_uns   = 1'($urandom_range(0, 1));
            r_addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 19));
            r_wdata = $urandom;
            ref_op(r_we, r_size, r_uns, r_addr, r_wdata, erd, eer, elat, ewes);
            do_req(r_we, r_size, r_uns, r_addr, r_wdata, rd, er, lat, wes);
            check($sformatf("rnd%0d_rdata", i), rd, erd);
            check($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, eer});
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_we_cycles", i), 32'(wes), 32'(ewes));
        end
        for (int w = 0; w < 4; w++)
            check($sformatf("rnd_mem_word%0d", w), mem[w], ref_mem[w]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
